// File: rtl/eeg_moving_avg.sv
// -----------------------------------------------------------------------------
// eeg_moving_avg
//
// Boxcar moving average over the last N = 2^WIN_LOG2 unsigned 8-bit EEG
// samples, with valid/ready handshakes on both sides and a one-clock
// result latency.
//
// The block starts in FILL and produces no output until the window holds N
// samples. From then on (RUN) every accepted sample produces one averaged
// output. flush clears the window synchronously. rst clears it
// asynchronously.
//
// Optional feature (compile-time macro EEG_AVG_SPIKE_EN):
//   When defined, spike flags a sample that exceeds the current window
//   average by more than SPIKE_TH. When undefined, spike is tied low.
//
// Parameters:
//   WIN_LOG2  log2 of the window length N (legal 1..6)
//   SPIKE_TH  spike threshold above the running average
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_data    8-bit unsigned input sample
//   in_valid   in_data is valid
//   in_ready   block can accept a sample this cycle
//   flush      synchronous clear of the window state
//   out_data   8-bit averaged sample
//   out_valid  out_data is valid
//   out_ready  downstream accepts out_data
//   spike      spike flag, qualified by out_valid
// -----------------------------------------------------------------------------
module eeg_moving_avg #(
    parameter int         WIN_LOG2 = 3,
    parameter logic [7:0] SPIKE_TH = 8'd40
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       flush,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       spike
);

    localparam int N  = 1 << WIN_LOG2;
    localparam int SW = 8 + WIN_LOG2;   // N * 255 always fits
    localparam int CW = WIN_LOG2 + 1;   // fill_cnt must be able to hold N
    localparam logic [CW-1:0] FILL_LAST = CW'(N - 1);

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t              state;
    logic [7:0]          win_buf [N];
    logic [WIN_LOG2-1:0] wr_ptr;
    logic [SW-1:0]       sum;
    logic [SW-1:0]       sum_next;
    logic [CW-1:0]       fill_cnt;
    logic [7:0]          oldest;
    logic                accept;
    logic                load_out;

    // The output register may take a new sample when it is empty or being
    // drained this cycle; flush blocks acceptance outright.
    assign in_ready = !flush && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // NOTE: every signal driven here gets a value on every path, so no
    // latch is inferred.
    always_comb begin
        oldest   = win_buf[wr_ptr];
        // Intermediate sum + in_data may exceed SW bits, but the modular
        // result after subtracting the evicted sample is exact.
        sum_next = sum + SW'(in_data) - SW'(oldest);
        load_out = accept && ((state == RUN) || (fill_cnt == FILL_LAST));
    end

    // NOTE: the window memory is cleared on reset and on flush because a
    // stale entry would be subtracted from the running sum; this forces the
    // buffer into flops rather than a RAM macro.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= FILL;
            wr_ptr    <= '0;
            sum       <= '0;
            fill_cnt  <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            for (int i = 0; i < N; i++) begin
                win_buf[i] <= '0;
            end
        end else if (flush) begin
            state     <= FILL;
            wr_ptr    <= '0;
            sum       <= '0;
            fill_cnt  <= '0;
            out_valid <= 1'b0;
            for (int i = 0; i < N; i++) begin
                win_buf[i] <= '0;
            end
        end else begin
            // Drain first; a simultaneous load below overrides this.
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                win_buf[wr_ptr] <= in_data;
                wr_ptr          <= wr_ptr + WIN_LOG2'(1);
                sum             <= sum_next;
                if (state == FILL) begin
                    fill_cnt <= fill_cnt + CW'(1);
                    if (fill_cnt == FILL_LAST) begin
                        state <= RUN;
                    end
                end
            end
            if (load_out) begin
                out_data  <= sum_next[SW-1:WIN_LOG2];
                out_valid <= 1'b1;
            end
        end
    end

`ifdef EEG_AVG_SPIKE_EN
    // Compare against the average before this sample enters the window.
    // Nine bits hold avg + threshold without wrapping.
    logic [8:0] spike_limit;
    logic       spike_next;
    logic       spike_q;

    assign spike_limit = {1'b0, sum[SW-1:WIN_LOG2]} + {1'b0, SPIKE_TH};
    assign spike_next  = {1'b0, in_data} > spike_limit;

    // load_out implies !flush, so the flag only changes alongside out_data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spike_q <= 1'b0;
        end else if (load_out) begin
            spike_q <= spike_next;
        end
    end

    assign spike = spike_q;
`else
    // Tied low; the AND with a constant folds away, it only keeps SPIKE_TH
    // referenced so the parameter list is identical in both builds.
    assign spike = 1'b0 & (|SPIKE_TH);
`endif

endmodule

// File: tb/tb_eeg_moving_avg.sv
// -----------------------------------------------------------------------------
// tb_eeg_moving_avg
//
// Directed bench for eeg_moving_avg at the default window (N = 8).
// Expected values are hand-computed in the comments next to each step.
// -----------------------------------------------------------------------------
module tb_eeg_moving_avg;

    logic       clk;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       flush;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       spike;

    int n_tests = 0;
    int n_fail  = 0;

    eeg_moving_avg dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .spike     (spike)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One accepted sample: drive, take the edge, sample 1 ns later.
    task automatic push(input logic [7:0] d);
        in_data   = d;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    task automatic idle(input logic rdy);
        in_valid  = 1'b0;
        out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    logic exp_spike60;

    initial begin
`ifdef EEG_AVG_SPIKE_EN
        exp_spike60 = 1'b1;   // 60 > 10 + 40
`else
        exp_spike60 = 1'b0;
`endif
        rst       = 1'b1;
        in_data   = 8'd0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;

        // ---- reset state ---------------------------------------------------
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_spike",     32'(spike),     32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // ---- fill with 16s: no output before the 8th -----------------------
        for (int i = 0; i < 7; i++) push(8'd16);
        check("fill7_out_valid", 32'(out_valid), 32'd0);
        push(8'd16);                              // sum 128 -> 16
        check("fill8_out_valid", 32'(out_valid), 32'd1);
        check("fill8_out_data",  32'(out_data),  32'd16);
        push(8'd32);                              // 128+32-16 = 144 -> 18
        check("run32_out_data",  32'(out_data),  32'd18);
        check("run32_out_valid", 32'(out_valid), 32'd1);
        idle(1'b1);
        check("drain_out_valid", 32'(out_valid), 32'd0);

        // ---- full scale, no overflow ---------------------------------------
        do_flush();
        check("flush_out_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < 8; i++) push(8'd255);  // sum 2040 -> 255
        check("max_out_data", 32'(out_data), 32'd255);
        push(8'd0);                               // 2040-255 = 1785 -> 223
        check("max0_out_data", 32'(out_data), 32'd223);

        // ---- backpressure: 5 stalled cycles with a pending sample ----------
        in_data   = 8'd100;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_in_ready",  32'(in_ready),  32'd0);
            @(posedge clk);
            #1;
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_out_data",  32'(out_data),  32'd223);
            check("bp_spike",     32'(spike),     32'd0);
        end
        push(8'd100);                             // 1785+100-255 = 1630 -> 203
        check("bp_rel_out_data",  32'(out_data),  32'd203);
        check("bp_rel_out_valid", 32'(out_valid), 32'd1);
        push(8'd100);                             // 1630+100-255 = 1475 -> 184
        check("bp_next_out_data", 32'(out_data),  32'd184);
        idle(1'b1);
        check("bp_drain_valid", 32'(out_valid), 32'd0);

        // ---- flush with a simultaneous valid sample ------------------------
        do_flush();
        for (int i = 0; i < 5; i++) push(8'd20);
        in_data  = 8'd200;
        in_valid = 1'b1;
        flush    = 1'b1;
        #1;
        check("flush_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 7; i++) push(8'd40);
        check("flush7_out_valid", 32'(out_valid), 32'd0);
        push(8'd40);                              // sum 320 -> 40, 200 dropped
        check("flush8_out_valid", 32'(out_valid), 32'd1);
        check("flush8_out_data",  32'(out_data),  32'd40);

        // ---- asynchronous reset between edges during RUN -------------------
        out_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_out_data",  32'(out_data),  32'd0);
        check("arst_spike",     32'(spike),     32'd0);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 7; i++) push(8'd8);
        check("arst7_out_valid", 32'(out_valid), 32'd0);
        push(8'd8);                               // sum 64 -> 8
        check("arst8_out_valid", 32'(out_valid), 32'd1);
        check("arst8_out_data",  32'(out_data),  32'd8);

        // ---- spike threshold -----------------------------------------------
        do_flush();
        for (int i = 0; i < 8; i++) push(8'd10);  // avg 70>>3 = 8 pre-update
        check("sp_fill_spike", 32'(spike), 32'd0);
        push(8'd60);                              // 80+60-10 = 130 -> 16
        check("sp60_out_data", 32'(out_data), 32'd16);
        check("sp60_spike",    32'(spike),    32'(exp_spike60));
        do_flush();
        for (int i = 0; i < 8; i++) push(8'd10);
        push(8'd50);                              // 80+50-10 = 120 -> 15
        check("sp50_out_data", 32'(out_data), 32'd15);
        check("sp50_spike",    32'(spike),    32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/eeg_moving_avg.md
EEG_MOVING_AVG -- requirements
Module: eeg_moving_avg

Interface
REQ-001 SHALL have parameter WIN_LOG2, default 3, meaning log2 of averaging window length N (N = 2^WIN_LOG2, legal 1..6).
REQ-002 SHALL have parameter SPIKE_TH, default 8'd40, meaning the spike-detect threshold, used only with EEG_AVG_SPIKE_EN.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port in_data, input, 8 bits: unsigned EEG sample from the upstream processing stage.
REQ-006 SHALL have port in_valid, input, 1 bit: in_data is valid this cycle.
REQ-007 SHALL have port in_ready, output, 1 bit: block can accept a sample this cycle.
REQ-008 SHALL have port flush, input, 1 bit: synchronous clear of window state.
REQ-009 SHALL have port out_data, output, 8 bits: the averaged sample.
REQ-010 SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream accepts out_data.
REQ-012 SHALL have port spike, output, 1 bit: spike flag, qualified by out_valid.

Function
REQ-013 SHALL define accept as in_valid & in_ready, and in_ready as !flush & (!out_valid | out_ready).
REQ-014 SHALL keep an N-entry circular buffer, write pointer wr_ptr (WIN_LOG2 bits, wraps N-1 -> 0), and running sum of width 8+WIN_LOG2 (never overflows).
REQ-015 On accept, SHALL compute sum_next = sum + in_data - buf[wr_ptr], then write buf[wr_ptr] = in_data and increment wr_ptr.
REQ-016 SHALL run FSM states FILL and RUN; FILL counts accepts in fill_cnt; FILL -> RUN on the accept that makes fill_cnt = N; RUN holds until flush or rst.
REQ-017 In FILL, before the N-th accept, SHALL update buffer and sum but SHALL NOT assert out_valid.
REQ-018 On the N-th accept and every accept in RUN, SHALL register out_data = sum_next >> WIN_LOG2 (truncating) and set out_valid the next cycle (latency 1 clock).
REQ-019 SHALL hold out_data and spike stable while out_valid & !out_ready.
REQ-020 SHALL clear out_valid on out_valid & out_ready with no accept in the same cycle; with a simultaneous accept, SHALL load the new result and keep out_valid high (full throughput, one sample per clock).
REQ-021 On flush, SHALL, in the same edge, zero buf, sum, wr_ptr, fill_cnt and out_valid and enter FILL; flush SHALL take priority over a simultaneous in_valid, which is not accepted.

Reset
REQ-022 On rst high, SHALL asynchronously set state = FILL, buf = 0, sum = 0, wr_ptr = 0, fill_cnt = 0, out_data = 0, out_valid = 0, spike = 0.
REQ-023 Mid-operation rst SHALL discard any pending output and partial window; after release, the first out_valid SHALL follow the N-th new accept.

Configuration
REQ-024 With EEG_AVG_SPIKE_EN defined, spike SHALL register (in_data > (sum >> WIN_LOG2) + SPIKE_TH), computed with the pre-update sum in 9+ bit arithmetic, whenever out_data is loaded.
REQ-025 Without EEG_AVG_SPIKE_EN, spike SHALL be tied to 0 and no comparator logic synthesised; port list unchanged.

Verification
REQ-026 N=8: 8 accepts of 16 -> out_valid only after the 8th, out_data = 16; then 32 -> out_data = 18 (sum 144).
REQ-027 8 accepts of 255 then 0 -> out_data 255 then 223; there SHALL be no sum overflow.
REQ-028 out_ready low 5 cycles with out_valid high -> in_ready = 0, out_data/spike stable; out_ready high plus in_valid -> new result in the next cycle, no loss or duplication.
REQ-029 Flush after 5 accepts with in_valid high -> sample dropped; 8 further accepts required before out_valid.
REQ-030 rst pulse asserted between clock edges during RUN -> outputs zero immediately; recovery per REQ-023.
REQ-031 EEG_AVG_SPIKE_EN, window of 10s then 60 -> spike = 1 with out_data = 16; 10s then 50 -> spike = 0 (50 = 10+40, not greater).
